dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width of the shared data memory (2^ADDR_W bytes).
REQ-002 Parameter DATA_W, default 32, word width (word_t).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 c_req  input  1  core (MEM-stage) access request.
REQ-006 c_we  input  1  core write (1) / read (0).
REQ-007 c_addr  input  DATA_W  core byte address.
REQ-008 c_wdata  input  DATA_W  core store data.
REQ-009 c_gnt  output  1  core access accepted this cycle.
REQ-010 c_stall  output  1  core must hold the MEM stage (c_req & ~c_gnt).
REQ-011 c_rvalid  output  1  core read data valid.
REQ-012 c_rdata  output  DATA_W  core read data.
REQ-013 l_req / l_we / l_addr / l_wdata  input  1/1/DATA_W/DATA_W  loader/debug port request, same meaning as core.
REQ-014 l_lock  input  1  loader holds the memory across consecutive requests (burst).
REQ-015 l_gnt / l_rvalid / l_rdata  output  1/1/DATA_W  loader grant, read valid, read data.
REQ-016 err  output  1  one-cycle pulse: a granted request was misaligned or out of range.
REQ-017 mem_addr / mem_wdata  output  DATA_W/DATA_W  to memory address and store data.
REQ-018 mem_rd / mem_wr  output  1/1  to memory read and write enables.
REQ-019 mem_rdata  input  DATA_W  memory combinational read data.

Function
REQ-020 FSM states IDLE, LOCKED; IDLE->LOCKED when loader is granted with l_lock=1; LOCKED->IDLE on the first cycle with l_lock=0.
REQ-021 At most one of c_gnt, l_gnt is high per cycle; grants are combinational from current requests and state.
REQ-022 In LOCKED, only the loader is granted; c_req is stalled.
REQ-023 In IDLE with a single requester, that requester is granted the same cycle.
REQ-024 In IDLE with both requesting, the core wins (fixed priority, unless REQ-036).
REQ-025 mem_* outputs mirror the granted port's fields; mem_rd/mem_wr are 0 when no grant or when the request is in error.
REQ-026 Writes commit at the rising edge ending the grant cycle.
REQ-027 Reads: mem_rdata captured at that edge; x_rvalid high for exactly the following cycle with x_rdata held until the next read for that port.
REQ-028 Error: addr[1:0]!=0 or addr > 2^ADDR_W-4 -> access suppressed, grant still given, err pulses next cycle, no rvalid.
REQ-029 Back-to-back grants to the same port every cycle are supported (throughput 1 access/cycle).
REQ-030 A request dropped before grant is discarded with no side effect.

Reset
REQ-031 rst takes effect at the next rising edge, overriding all requests in that cycle.
REQ-032 After reset: state IDLE, c_rvalid=l_rvalid=0, c_rdata=l_rdata=0, err=0, RR pointer = core.
REQ-033 While rst is high, c_gnt=l_gnt=0 and mem_rd=mem_wr=0; no write commits.
REQ-034 Reset during LOCKED returns to IDLE; a read granted in the reset cycle produces no rvalid.

Configuration
REQ-035 Macro DMEM_ARB_RR_EN selects the IDLE conflict policy.
REQ-036 Defined: round-robin; on conflict, the port not granted last wins; pointer updates on every grant.
REQ-037 Undefined: fixed core-first priority per REQ-024; no pointer register.

Verification
REQ-038 Core write 0xDEADBEEF @0x08, then read @0x08 -> c_gnt both cycles, c_rvalid next cycle, c_rdata=0xDEADBEEF.
REQ-039 Both request same cycle, IDLE -> c_gnt=1, l_gnt=0, c_stall=0; RR build: loader wins next conflict.
REQ-040 Loader l_lock=1 for 4 writes @0x00..0x0C, core requests throughout -> c_stall=1 all 4 cycles, core granted cycle after l_lock=0.
REQ-041 Core read @0x06 and loader read @0x20 -> err pulses each, mem_rd=0, no rvalid.
REQ-042 rst asserted cycle after a loader locked read -> l_rvalid=0, state IDLE, next core request granted immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core / loader) arbiter in front of a single shared
// data memory. Grants are combinational; read data, read-valid and error
// flags are registered. A loader burst (l_lock) holds the memory exclusively.
// Optional macro DMEM_ARB_RR_EN replaces core-first priority with round-robin
// on IDLE conflicts.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [DATA_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Highest legal word-aligned byte address.
    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'((1 << ADDR_W) - 4);

    state_t state;
    logic   sel_we;
    logic   sel_bad;
    logic   any_gnt;

`ifdef DMEM_ARB_RR_EN
    // 1: core wins the next IDLE conflict, 0: loader wins.
    logic   prio_core;
`endif

    // Grant selection from current requests and arbitration state.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCKED) begin
                l_gnt = l_req;
            end else if (c_req && l_req) begin
`ifdef DMEM_ARB_RR_EN
                c_gnt = prio_core;
                l_gnt = ~prio_core;
`else
                c_gnt = 1'b1;
`endif
            end else begin
                c_gnt = c_req;
                l_gnt = l_req;
            end
        end
    end

    // Steer the granted port onto the memory bus; suppress bad accesses.
    always_comb begin
        if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            sel_we    = l_we;
        end else begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            sel_we    = c_we;
        end
        sel_bad = (mem_addr[1:0] != 2'b00) || (mem_addr > MAX_ADDR);
        any_gnt = c_gnt | l_gnt;
        mem_rd  = any_gnt & ~sel_we & ~sel_bad;
        mem_wr  = any_gnt & sel_we & ~sel_bad;
        c_stall = c_req & ~c_gnt;
    end

    // Lock FSM, registered read returns, error pulse and RR pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rdata  <= '0;
            err      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            prio_core <= 1'b1;
`endif
        end else begin
            err      <= any_gnt & sel_bad;
            c_rvalid <= c_gnt & ~sel_we & ~sel_bad;
            l_rvalid <= l_gnt & ~sel_we & ~sel_bad;
            if (c_gnt && !sel_we && !sel_bad) begin
                c_rdata <= mem_rdata;
            end
            if (l_gnt && !sel_we && !sel_bad) begin
                l_rdata <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (l_gnt && l_lock) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (!l_lock) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef DMEM_ARB_RR_EN
            if (c_gnt) begin
                prio_core <= 1'b0;
            end else if (l_gnt) begin
                prio_core <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A behavioural memory
// sits on the mem_* bus; a shadow array predicts read data. Read returns and
// error pulses are queued with the cycle they are due and checked by a monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_next = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic        c_gnt, c_stall, c_rvalid, l_gnt, l_rvalid, err, mem_rd, mem_wr;
    logic [31:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  ctl;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        c_q[$];
    exp_t        l_q[$];
    int unsigned err_q[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem   [0:7];
    logic [31:0] model [0:7];

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign ctl       = {c_gnt, l_gnt, c_stall, mem_rd, mem_wr};
    assign mem_rdata = mem[mem_addr[4:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) mem[mem_addr[4:2]] <= mem_wdata;
    end

    // Scoreboard monitor: registered outputs are checked mid-cycle.
    always @(negedge clk) begin
        total++;
        if (c_q.size() > 0 && c_q[0].due == cyc) begin
            if (c_rvalid !== 1'b1 || c_rdata !== c_q[0].data) begin
                bad++;
                $display("FAIL c_read cyc=%0d got rvalid=%b data=%h exp rvalid=1 data=%h",
                         cyc, c_rvalid, c_rdata, c_q[0].data);
            end
            void'(c_q.pop_front());
        end else if (c_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL c_rvalid_idle cyc=%0d got=%b exp=0", cyc, c_rvalid);
        end
        total++;
        if (l_q.size() > 0 && l_q[0].due == cyc) begin
            if (l_rvalid !== 1'b1 || l_rdata !== l_q[0].data) begin
                bad++;
                $display("FAIL l_read cyc=%0d got rvalid=%b data=%h exp rvalid=1 data=%h",
                         cyc, l_rvalid, l_rdata, l_q[0].data);
            end
            void'(l_q.pop_front());
        end else if (l_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL l_rvalid_idle cyc=%0d got=%b exp=0", cyc, l_rvalid);
        end
        total++;
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            if (err !== 1'b1) begin
                bad++;
                $display("FAIL err_pulse cyc=%0d got=%b exp=1", cyc, err);
            end
            void'(err_q.pop_front());
        end else if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_idle cyc=%0d got=%b exp=0", cyc, err);
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                         input logic lk);
        @(negedge clk);
        rst = rst_next;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 1, 32'h10, 32'h1111_1111, 1, 0, 32'h04, 0, 1);
        total++;
        if (ctl !== 5'b00100) begin
            bad++; $display("FAIL reset_ctl got=%b exp=00100", ctl);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if ({c_rvalid, l_rvalid, err, c_rdata, l_rdata} !== 67'd0) begin
            bad++;
            $display("FAIL reset_regs got=%b%b%b %h %h exp=000 0 0", c_rvalid, l_rvalid, err, c_rdata, l_rdata);
        end
        rst_next = 1'b0;
    endtask

    task automatic test_core_rw;
        drive(1, 1, 32'h08, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10001 || mem_addr !== 32'h08 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL core_wr got=%b %h %h exp=10001 8 deadbeef", ctl, mem_addr, mem_wdata);
        end
        model[2] = 32'hDEAD_BEEF;
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10010) begin
            bad++; $display("FAIL core_rd10 got=%b exp=10010", ctl);
        end
        c_q.push_back('{cyc + 1, model[4]});
        drive(1, 0, 32'h08, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10010 || mem_addr !== 32'h08) begin
            bad++; $display("FAIL core_rd08 got=%b %h exp=10010 8", ctl, mem_addr);
        end
        c_q.push_back('{cyc + 1, model[2]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (c_rdata !== 32'hDEAD_BEEF || ctl !== 5'b00000) begin
            bad++; $display("FAIL core_hold got=%h %b exp=deadbeef 00000", c_rdata, ctl);
        end
    endtask

    task automatic test_lock;
        drive(0, 0, 0, 0, 1, 1, 32'h00, 32'hA000_0000, 1);
        total++;
        if (ctl !== 5'b01001) begin
            bad++; $display("FAIL lock_start got=%b exp=01001", ctl);
        end
        model[0] = 32'hA000_0000;
        for (int i = 1; i < 4; i++) begin
            drive(1, 1, 32'h10, 32'h0BAD_0BAD, 1, 1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1);
            total++;
            if (ctl !== 5'b01101 || mem_addr !== 32'(4 * i)) begin
                bad++; $display("FAIL lock_burst%0d got=%b %h exp=01101 %h", i, ctl, mem_addr, 4 * i);
            end
            model[i] = 32'hA000_0000 + 32'(i);
        end
        drive(1, 0, 32'h08, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b00100) begin
            bad++; $display("FAIL lock_release got=%b exp=00100", ctl);
        end
        drive(1, 0, 32'h08, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10010) begin
            bad++; $display("FAIL lock_core_after got=%b exp=10010", ctl);
        end
        c_q.push_back('{cyc + 1, model[2]});
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
        total++;
        if (ctl !== 5'b01010) begin
            bad++; $display("FAIL lock_dropped_chk got=%b exp=01010", ctl);
        end
        l_q.push_back('{cyc + 1, model[4]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_conflict;
        drive(1, 0, 32'h08, 0, 1, 0, 32'h04, 0, 0);
        total++;
        if (ctl !== 5'b10010 || mem_addr !== 32'h08) begin
            bad++; $display("FAIL conflict1 got=%b %h exp=10010 8", ctl, mem_addr);
        end
        c_q.push_back('{cyc + 1, model[2]});
        drive(1, 0, 32'h0C, 0, 1, 0, 32'h04, 0, 0);
`ifdef DMEM_ARB_RR_EN
        total++;
        if (ctl !== 5'b01110 || mem_addr !== 32'h04) begin
            bad++; $display("FAIL conflict2_rr got=%b %h exp=01110 4", ctl, mem_addr);
        end
        l_q.push_back('{cyc + 1, model[1]});
`else
        total++;
        if (ctl !== 5'b10010 || mem_addr !== 32'h0C) begin
            bad++; $display("FAIL conflict2_fixed got=%b %h exp=10010 c", ctl, mem_addr);
        end
        c_q.push_back('{cyc + 1, model[3]});
`endif
        drive(0, 0, 0, 0, 1, 0, 32'h04, 0, 0);
        total++;
        if (ctl !== 5'b01010) begin
            bad++; $display("FAIL conflict_loader_alone got=%b exp=01010", ctl);
        end
        l_q.push_back('{cyc + 1, model[1]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_error;
        drive(1, 0, 32'h06, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10000) begin
            bad++; $display("FAIL err_core_mis got=%b exp=10000", ctl);
        end
        err_q.push_back(cyc + 1);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
        total++;
        if (ctl !== 5'b01000) begin
            bad++; $display("FAIL err_l_range got=%b exp=01000", ctl);
        end
        err_q.push_back(cyc + 1);
        drive(1, 1, 32'h01, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10000) begin
            bad++; $display("FAIL err_core_wr got=%b exp=10000", ctl);
        end
        err_q.push_back(cyc + 1);
        drive(0, 0, 0, 0, 1, 1, 32'h1C, 32'h5A5A_5A5A, 0);
        total++;
        if (ctl !== 5'b01001) begin
            bad++; $display("FAIL edge_wr1c got=%b exp=01001", ctl);
        end
        model[7] = 32'h5A5A_5A5A;
        drive(1, 0, 32'h1C, 0, 0, 0, 0, 0, 0);
        total++;
        if (ctl !== 5'b10010) begin
            bad++; $display("FAIL edge_rd1c got=%b exp=10010", ctl);
        end
        c_q.push_back('{cyc + 1, model[7]});
        drive(1, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        c_q.push_back('{cyc + 1, model[0]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 1, 32'h10 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0);
            total++;
            if (ctl !== 5'b01001) begin
                bad++; $display("FAIL b2b_wr%0d got=%b exp=01001", i, ctl);
            end
            model[4 + i] = 32'hB000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h10 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
            total++;
            if (ctl !== 5'b10010) begin
                bad++; $display("FAIL b2b_rd%0d got=%b exp=10010", i, ctl);
            end
            c_q.push_back('{cyc + 1, model[4 + i]});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_locked;
        drive(0, 0, 0, 0, 1, 0, 32'h04, 0, 1);
        total++;
        if (ctl !== 5'b01010) begin
            bad++; $display("FAIL rl_locked_rd got=%b exp=01010", ctl);
        end
        l_q.push_back('{cyc + 1, model[1]});
        rst_next = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 32'h08, 0, 1);
        total++;
        if (ctl !== 5'b00000) begin
            bad++; $display("FAIL rl_rst_cycle got=%b exp=00000", ctl);
        end
        rst_next = 1'b0;
        drive(1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 1);
        total++;
        if (ctl !== 5'b10010 || l_rdata !== 32'h0) begin
            bad++; $display("FAIL rl_after got=%b %h exp=10010 0", ctl, l_rdata);
        end
        c_q.push_back('{cyc + 1, model[1]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end
        test_reset;
        test_core_rw;
        test_lock;
        test_conflict;
        test_error;
        test_back_to_back;
        test_reset_locked;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (c_q.size() + l_q.size() + err_q.size() != 0) begin
            bad++;
            $display("FAIL pending got=%0d exp=0", c_q.size() + l_q.size() + err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
